// File: rtl/unified_mem_loader.sv
// Unified instruction/data memory with a boot loader front end: streams load beats
// into memory while holding the processor in reset, then hands the memory to the processor.
module unified_mem_loader #(
  parameter int N  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] mem_rd_addr1,
  output logic [N-1:0]  mem_rd_data1,
  input  logic [AW-1:0] mem_rd_addr2,
  output logic [N-1:0]  mem_rd_data2,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_wr_addr,
  input  logic [N-1:0]  mem_wr_data,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [N-1:0]  load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          cpu_reset,
  output logic [AW:0]   load_count
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] load_ptr;
  logic [N-1:0]  mem [DEPTH];

  logic accept;
  logic last_slot;

  assign accept    = (state == LOAD) && load_valid;
  assign last_slot = (load_ptr == {AW{1'b1}});

  // Both handshake outputs come straight from the state register.
  assign load_ready = (state == LOAD);
  assign cpu_reset  = (state == LOAD);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      load_ptr   <= '0;
      load_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            load_ptr   <= load_ptr + AW'(1);
            load_count <= load_count + (AW+1)'(1);
            // Filling the final word ends the load even without load_last.
            if (load_last || last_slot) state <= RUN;
          end
        end
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            load_ptr   <= '0;
            load_count <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[load_ptr] <= load_data;
    end else if ((state == RUN) && mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  assign mem_rd_data1 = mem[mem_rd_addr1];
  assign mem_rd_data2 = mem[mem_rd_addr2];

endmodule

// File: tb/tb_unified_mem_loader.sv
// Self-checking bench for unified_mem_loader: load beats are recorded in a scoreboard
// queue and compared against the read ports once the load has finished.
module tb_unified_mem_loader;

  localparam int N  = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_rd_addr1, mem_rd_addr2;
  logic [N-1:0]  mem_rd_data1, mem_rd_data2;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [N-1:0]  mem_wr_data;
  logic          load_start, load_valid, load_last;
  logic [N-1:0]  load_data;
  logic          load_ready, cpu_reset;
  logic [AW:0]   load_count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] exp_ptr;
  int            n_checks = 0;
  int            n_fail   = 0;

  unified_mem_loader #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .mem_rd_addr1(mem_rd_addr1), .mem_rd_data1(mem_rd_data1),
    .mem_rd_addr2(mem_rd_addr2), .mem_rd_data2(mem_rd_data2),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .cpu_reset(cpu_reset),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [N-1:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    sb.push_back('{exp_ptr, data});
    exp_ptr    = exp_ptr + AW'(1);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic run_write(input logic [AW-1:0] addr, input logic [N-1:0] data);
    mem_wr_en   = 1'b1;
    mem_wr_addr = addr;
    mem_wr_data = data;
    tick();
    mem_wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_checks++;
    if (cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: cpu_reset=%b load_ready=%b, required 1/1", cpu_reset, load_ready);
    end
    n_checks++;
    if (load_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d, required 0", load_count);
    end
    tick();
    reset   = 1'b0;
    exp_ptr = '0;
  endtask

  task automatic test_basic_load();
    beat(8'hA1, 1'b0);
    beat(8'hB2, 1'b0);
    n_checks++;
    if (cpu_reset !== 1'b1 || load_count !== 9'd2) begin
      n_fail++;
      $display("FAIL load_midway: cpu_reset=%b count=%0d, required 1/2", cpu_reset, load_count);
    end
    beat(8'hC3, 1'b1);
    n_checks++;
    if (cpu_reset !== 1'b0 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_to_run: cpu_reset=%b load_ready=%b, required 0/0", cpu_reset, load_ready);
    end
    n_checks++;
    if (load_count !== 9'd3) begin
      n_fail++;
      $display("FAIL load_count3: got %0d, required 3", load_count);
    end
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      mem_rd_addr1 = e.addr;
      #1;
      n_checks++;
      if (mem_rd_data1 !== e.data) begin
        n_fail++;
        $display("FAIL basic_mem[%0d]: got %h, required %h", e.addr, mem_rd_data1, e.data);
      end
    end
  endtask

  task automatic test_run_write();
    mem_rd_addr2 = 8'h10;
    run_write(8'h10, 8'h77);
    n_checks++;
    if (mem_rd_data2 !== 8'h77) begin
      n_fail++;
      $display("FAIL run_write_first: got %h, required 77", mem_rd_data2);
    end
    mem_wr_en   = 1'b1;
    mem_wr_addr = 8'h10;
    mem_wr_data = 8'h5A;
    #1;
    n_checks++;
    if (mem_rd_data2 !== 8'h77) begin
      n_fail++;
      $display("FAIL no_write_through: got %h, required 77", mem_rd_data2);
    end
    tick();
    mem_wr_en = 1'b0;
    n_checks++;
    if (mem_rd_data2 !== 8'h5A) begin
      n_fail++;
      $display("FAIL run_write_after_edge: got %h, required 5a", mem_rd_data2);
    end
  endtask

  task automatic test_load_ignores_writes();
    run_write(8'h20, 8'h44);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_ptr    = '0;
    n_checks++;
    if (cpu_reset !== 1'b1 || load_count !== '0) begin
      n_fail++;
      $display("FAIL restart: cpu_reset=%b count=%0d, required 1/0", cpu_reset, load_count);
    end
    beat(8'hD0, 1'b0);
    run_write(8'h20, 8'hFF);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    beat(8'hD1, 1'b1);
    n_checks++;
    if (cpu_reset !== 1'b0 || load_count !== 9'd2) begin
      n_fail++;
      $display("FAIL start_in_load: cpu_reset=%b count=%0d, required 0/2", cpu_reset, load_count);
    end
    mem_rd_addr2 = 8'h20;
    #1;
    n_checks++;
    if (mem_rd_data2 !== 8'h44) begin
      n_fail++;
      $display("FAIL load_ignores_wr: got %h, required 44", mem_rd_data2);
    end
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      mem_rd_addr2 = e.addr;
      #1;
      n_checks++;
      if (mem_rd_data2 !== e.data) begin
        n_fail++;
        $display("FAIL restart_mem[%0d]: got %h, required %h", e.addr, mem_rd_data2, e.data);
      end
    end
  endtask

  task automatic test_full_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_ptr    = '0;
    for (int i = 0; i < 255; i++) beat(N'(i) ^ 8'h5A, 1'b0);
    n_checks++;
    if (cpu_reset !== 1'b1 || load_count !== 9'd255) begin
      n_fail++;
      $display("FAIL full_before_last: cpu_reset=%b count=%0d, required 1/255", cpu_reset, load_count);
    end
    beat(8'hFF ^ 8'h5A, 1'b0);
    n_checks++;
    if (cpu_reset !== 1'b0 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_to_run: cpu_reset=%b load_ready=%b, required 0/0", cpu_reset, load_ready);
    end
    n_checks++;
    if (load_count !== 9'd256) begin
      n_fail++;
      $display("FAIL full_count: got %0d, required 256", load_count);
    end
    n_checks++;
    if (dut.load_ptr !== '0) begin
      n_fail++;
      $display("FAIL full_ptr_wrap: got %0d, required 0", dut.load_ptr);
    end
    // Load beats presented in RUN must not write or count.
    load_valid = 1'b1;
    load_last  = 1'b1;
    load_data  = 8'hEE;
    tick();
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    n_checks++;
    if (load_count !== 9'd256 || cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL run_ignores_load: count=%0d cpu_reset=%b, required 256/0", load_count, cpu_reset);
    end
    for (int i = 0; sb.size() > 0; i++) begin
      exp_t e = sb.pop_front();
      mem_rd_addr1 = e.addr;
      mem_rd_addr2 = e.addr;
      #1;
      n_checks++;
      if (((i % 2) == 0 ? mem_rd_data1 : mem_rd_data2) !== e.data) begin
        n_fail++;
        $display("FAIL full_mem[%0d]: got %h/%h, required %h", e.addr, mem_rd_data1, mem_rd_data2, e.data);
      end
    end
  endtask

  task automatic test_start_with_write();
    load_start  = 1'b1;
    mem_wr_en   = 1'b1;
    mem_wr_addr = 8'h05;
    mem_wr_data = 8'h33;
    tick();
    load_start = 1'b0;
    mem_wr_en  = 1'b0;
    exp_ptr    = '0;
    mem_rd_addr1 = 8'h05;
    #1;
    n_checks++;
    if (mem_rd_data1 !== 8'h33) begin
      n_fail++;
      $display("FAIL start_write_mem: got %h, required 33", mem_rd_data1);
    end
    n_checks++;
    if (cpu_reset !== 1'b1 || load_ready !== 1'b1 || load_count !== '0) begin
      n_fail++;
      $display("FAIL start_write_state: cpu_reset=%b ready=%b count=%0d, required 1/1/0",
               cpu_reset, load_ready, load_count);
    end
  endtask

  task automatic test_reset_mid_load();
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    void'(sb.pop_front());
    reset = 1'b1;
    #2;
    reset   = 1'b0;
    exp_ptr = '0;
    n_checks++;
    if (load_count !== '0 || cpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_load_reset: count=%0d cpu_reset=%b, required 0/1", load_count, cpu_reset);
    end
    beat(8'h99, 1'b1);
    n_checks++;
    if (load_count !== 9'd1 || cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_after_reset: count=%0d cpu_reset=%b, required 1/0", load_count, cpu_reset);
    end
    // mem[1] keeps 0x22 from before the reset; mem[0] now holds 0x99.
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      mem_rd_addr1 = e.addr;
      #1;
      n_checks++;
      if (mem_rd_data1 !== e.data) begin
        n_fail++;
        $display("FAIL reset_mem[%0d]: got %h, required %h", e.addr, mem_rd_data1, e.data);
      end
    end
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mem_rd_addr1 = 8'h00;
    mem_rd_addr2 = 8'h01;
    #1;
    n_checks++;
    if (cpu_reset !== 1'b1 || mem_rd_data1 !== 8'h99 || mem_rd_data2 !== 8'h22) begin
      n_fail++;
      $display("FAIL run_reset_retain: cpu_reset=%b mem0=%h mem1=%h, required 1/99/22",
               cpu_reset, mem_rd_data1, mem_rd_data2);
    end
  endtask

  initial begin
    reset        = 1'b0;
    mem_rd_addr1 = '0;
    mem_rd_addr2 = '0;
    mem_wr_en    = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    load_start   = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    load_last    = 1'b0;
    exp_ptr      = '0;
    #2;
    test_reset();
    test_basic_load();
    test_run_write();
    test_load_ignores_writes();
    test_full_load();
    test_start_with_write();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_loader.md
UNIFIED_MEM_LOADER -- requirements
Module: unified_mem_loader

Interface
REQ-001 The block SHALL have parameter N, default 8: data width in bits.
REQ-002 The block SHALL have parameter AW, default 8: address width; depth is 2**AW words.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port mem_rd_addr1, input, AW bits: instruction read address.
REQ-006 The block SHALL have port mem_rd_data1, output, N bits: the word at mem_rd_addr1.
REQ-007 The block SHALL have port mem_rd_addr2, input, AW bits: data read address.
REQ-008 The block SHALL have port mem_rd_data2, output, N bits: the word at mem_rd_addr2.
REQ-009 The block SHALL have port mem_wr_en, input, 1 bit: processor write strobe.
REQ-010 The block SHALL have port mem_wr_addr, input, AW bits: processor write address.
REQ-011 The block SHALL have port mem_wr_data, input, N bits: processor write data.
REQ-012 The block SHALL have port load_start, input, 1 bit: single-cycle pulse that requests a reload.
REQ-013 The block SHALL have port load_valid, input, 1 bit: a load beat is presented.
REQ-014 The block SHALL have port load_data, input, N bits: the load beat payload.
REQ-015 The block SHALL have port load_last, input, 1 bit: marks the final load beat.
REQ-016 The block SHALL have port load_ready, output, 1 bit: the block accepts load beats.
REQ-017 The block SHALL have port cpu_reset, output, 1 bit: holds the attached processor in reset.
REQ-018 The block SHALL have port load_count, output, AW+1 bits: number of beats accepted in the current load.

Function
REQ-019 Storage SHALL be 2**AW words of N bits, with contents not cleared by reset.
REQ-020 Both read ports SHALL be combinational (mem_rd_dataX = mem[mem_rd_addrX]) and valid in all states.
REQ-021 A word written at edge k SHALL be visible on the read ports after edge k; it SHALL NOT be visible before that edge, so there is no write-through.
REQ-022 The block SHALL implement a two-state FSM: LOAD and RUN.
REQ-023 In LOAD, load_ready SHALL be 1 and cpu_reset SHALL be 1; in RUN, both SHALL be 0. Both outputs SHALL be decoded from the state register only.
REQ-024 A beat SHALL be accepted when load_valid and load_ready are both 1 at a clock edge.
REQ-025 On an accepted beat, the block SHALL write mem[load_ptr] <= load_data, increment load_ptr (AW bits) and increment load_count.
REQ-026 An accepted beat with load_last=1 SHALL be written, and the state SHALL move LOAD->RUN at the same edge.
REQ-027 An accepted beat with load_ptr = 2**AW-1 SHALL be written, and the state SHALL move LOAD->RUN at the same edge even if load_last=0. load_ptr SHALL wrap to 0 and load_count SHALL equal 2**AW.
REQ-028 In LOAD, mem_wr_en SHALL be ignored.
REQ-029 In RUN, load_valid and load_last SHALL be ignored.
REQ-030 In RUN with mem_wr_en=1, the block SHALL write mem[mem_wr_addr] <= mem_wr_data at the edge.
REQ-031 In RUN, load_start=1 SHALL move the state RUN->LOAD and clear load_ptr and load_count to 0.
REQ-032 If mem_wr_en and load_start are both 1 in the same RUN cycle, the processor write SHALL still complete.
REQ-033 In LOAD, load_start SHALL be ignored and SHALL NOT restart the pointer.
REQ-034 load_count SHALL hold its final value in RUN until the next load_start or reset.

Reset
REQ-035 Reset SHALL set state=LOAD, load_ptr=0 and load_count=0, giving cpu_reset=1 and load_ready=1.
REQ-036 Reset asserted mid-load SHALL restart loading at address 0; words already written SHALL be retained.
REQ-037 Reset asserted mid-RUN SHALL return the block to LOAD, with memory contents retained.

Verification
REQ-038 The bench SHALL cover: reset, then beats 0xA1, 0xB2, 0xC3 (last on 0xC3) -> mem[0..2]=A1,B2,C3; RUN on the following cycle; cpu_reset=0; load_count=3; mem_rd_data1 at addr 1 = 0xB2.
REQ-039 The bench SHALL cover: in RUN, write 0x5A to addr 0x10 with mem_rd_addr2=0x10 -> mem_rd_data2 shows the old value before the edge and 0x5A after it.
REQ-040 The bench SHALL cover: in LOAD, mem_wr_en=1 with addr 0x20, data 0xFF -> mem[0x20] unchanged.
REQ-041 The bench SHALL cover: 256 beats with load_last=0 -> RUN entered after beat 256; load_count=256; load_ptr=0.
REQ-042 The bench SHALL cover: in RUN, load_start with mem_wr_en (addr 0x05, data 0x33) in the same cycle -> mem[0x05]=0x33; LOAD; cpu_reset=1; load_count=0.
REQ-043 The bench SHALL cover: reset after 2 beats (0x11, 0x22), then beat 0x99 with last -> mem[0]=0x99, mem[1]=0x22, load_count=1.
